// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel PWM LED sequencer (off / static / blink / breathe) feeding SB_RGBA_DRV PWM pins.
// Config words wait in a single slot and only take effect at a PWM period boundary.
module rgb_pwm_sequencer #(
  parameter int unsigned NUM_CH        = 3,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE      = 4,
  parameter int unsigned BLINK_PERIODS = 64,
  parameter int unsigned STEP          = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                period_end
);

  localparam int unsigned PresW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BlinkW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] PwmMax    = '1;
  localparam logic [PresW-1:0]    PresLast  = PresW'(PRESCALE - 1);
  localparam logic [BlinkW-1:0]   BlinkLast = BlinkW'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS:0]   StepW     = (PWM_BITS + 1)'(STEP);

  typedef enum logic [1:0] {
    ModeOff     = 2'b00,
    ModeStatic  = 2'b01,
    ModeBlink   = 2'b10,
    ModeBreathe = 2'b11
  } mode_e;

  logic [PresW-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic                tick, pe;

  logic                pend_q, pend_d;
  logic [2:0]          pend_ch_q, pend_ch_d;
  mode_e               pend_mode_q, pend_mode_d;
  logic [PWM_BITS-1:0] pend_level_q, pend_level_d;

  mode_e               mode_q  [NUM_CH];
  mode_e               mode_d  [NUM_CH];
  logic [PWM_BITS-1:0] level_q [NUM_CH];
  logic [PWM_BITS-1:0] level_d [NUM_CH];
  logic [PWM_BITS-1:0] ramp_q  [NUM_CH];
  logic [PWM_BITS-1:0] ramp_d  [NUM_CH];
  logic [PWM_BITS:0]   ramp_up [NUM_CH];
  logic [PWM_BITS-1:0] duty    [NUM_CH];
  logic [NUM_CH-1:0]   dir_q, dir_d;  // 1 = ramping down
  logic [NUM_CH-1:0]   pwm_d;

  assign tick      = en && (presc_q == PresLast);
  assign pe        = tick && (pwm_cnt_q == PwmMax);
  assign cfg_ready = !pend_q;

  // Timebase and global blink phase
  always_comb begin
    presc_d     = presc_q;
    pwm_cnt_d   = pwm_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!en) begin
      presc_d   = '0;
      pwm_cnt_d = '0;
    end else if (tick) begin
      presc_d   = '0;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (pe) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Single-entry config slot; pending_q blocks new words until the commit
  always_comb begin
    pend_d       = pend_q;
    pend_ch_d    = pend_ch_q;
    pend_mode_d  = pend_mode_q;
    pend_level_d = pend_level_q;
    if (pe && pend_q) begin
      pend_d = 1'b0;
    end else if (cfg_valid && !pend_q) begin
      pend_d       = 1'b1;
      pend_ch_d    = cfg_ch;
      pend_mode_d  = mode_e'(cfg_mode);
      pend_level_d = cfg_level;
    end
  end

  // Per-channel state: a commit on a channel takes precedence over its ramp advance
  always_comb begin
    mode_d  = mode_q;
    level_d = level_q;
    ramp_d  = ramp_q;
    dir_d   = dir_q;
    for (int i = 0; i < NUM_CH; i++) begin
      ramp_up[i] = {1'b0, ramp_q[i]} + StepW;
      if (pe) begin
        if (pend_q && (pend_ch_q == 3'(i))) begin
          mode_d[i]  = pend_mode_q;
          level_d[i] = pend_level_q;
          if (pend_mode_q != mode_q[i]) begin
            ramp_d[i] = '0;
            dir_d[i]  = 1'b0;
          end else if (ramp_q[i] > pend_level_q) begin
            ramp_d[i] = pend_level_q;
          end
        end else if (mode_q[i] == ModeBreathe) begin
          if (!dir_q[i]) begin
            if (ramp_up[i] >= {1'b0, level_q[i]}) begin
              ramp_d[i] = level_q[i];
              dir_d[i]  = 1'b1;
            end else begin
              ramp_d[i] = ramp_up[i][PWM_BITS-1:0];
            end
          end else begin
            if ({1'b0, ramp_q[i]} <= StepW) begin
              ramp_d[i] = '0;
              dir_d[i]  = 1'b0;
            end else begin
              ramp_d[i] = ramp_q[i] - StepW[PWM_BITS-1:0];
            end
          end
        end
      end
    end
  end

  // Duty select and compare; full-scale duty means constant high
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      duty[i] = '0;
      case (mode_q[i])
        ModeOff:     duty[i] = '0;
        ModeStatic:  duty[i] = level_q[i];
        ModeBlink:   duty[i] = phase_q ? '0 : level_q[i];
        ModeBreathe: duty[i] = ramp_q[i];
      endcase
      pwm_d[i] = en && ((duty[i] == PwmMax) || (pwm_cnt_q < duty[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      pwm_cnt_q    <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_ch_q    <= '0;
      pend_mode_q  <= ModeOff;
      pend_level_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]  <= ModeOff;
        level_q[i] <= '0;
        ramp_q[i]  <= '0;
      end
      dir_q      <= '0;
      pwm_out    <= '0;
      period_end <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      pend_ch_q    <= pend_ch_d;
      pend_mode_q  <= pend_mode_d;
      pend_level_q <= pend_level_d;
      mode_q       <= mode_d;
      level_q      <= level_d;
      ramp_q       <= ramp_d;
      dir_q        <= dir_d;
      pwm_out      <= pwm_d;
      period_end   <= pe;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Bench for rgb_pwm_sequencer: period-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed per-period high counts.
module tb_rgb_pwm_sequencer;

  localparam int NCH    = 3;
  localparam int PERIOD = 16;
  localparam int LMAX   = 15;
  localparam int BP     = 2;
  localparam int STP    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_level = '0;
  logic [2:0] pwm_out;
  logic       period_end;

  int n_checks = 0;
  int n_fail = 0;

  rgb_pwm_sequencer #(
    .NUM_CH(3), .PWM_BITS(4), .PRESCALE(1), .BLINK_PERIODS(2), .STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
    .pwm_out(pwm_out), .period_end(period_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position in period, periods elapsed, per-channel mode/level/ramp as integers
  int   m_pos = 0;
  int   m_periods = 0;
  int   m_mode [NCH];
  int   m_level [NCH];
  int   m_ramp [NCH];
  int   m_dir [NCH];
  bit   m_pend = 0;
  bit   m_was_pend;
  bit   m_pe_now;
  int   m_pch, m_pmode, m_plevel;
  logic [2:0] exp_pwm = '0;
  logic exp_pe = 1'b0;
  logic exp_ready = 1'b1;

  function automatic int duty_of(input int i);
    case (m_mode[i])
      0:       return 0;
      1:       return m_level[i];
      2:       return (((m_periods / BP) % 2) != 0) ? 0 : m_level[i];
      default: return m_ramp[i];
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0;
      m_periods = 0;
      m_pend = 0;
      exp_pwm = '0;
      exp_pe = 1'b0;
      exp_ready = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0;
        m_level[i] = 0;
        m_ramp[i] = 0;
        m_dir[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++)
        exp_pwm[i] = en && (duty_of(i) == LMAX || m_pos < duty_of(i));
      m_pe_now = en && (m_pos == PERIOD - 1);
      exp_pe = m_pe_now;
      m_pos = en ? (m_pos + 1) % PERIOD : 0;
      m_was_pend = m_pend;
      if (m_pe_now) begin
        m_periods++;
        for (int i = 0; i < NCH; i++) begin
          if (m_was_pend && m_pch == i) begin
            if (m_pmode != m_mode[i]) begin
              m_ramp[i] = 0;
              m_dir[i] = 0;
            end else if (m_ramp[i] > m_plevel) begin
              m_ramp[i] = m_plevel;
            end
            m_mode[i] = m_pmode;
            m_level[i] = m_plevel;
          end else if (m_mode[i] == 3) begin
            if (m_dir[i] == 0) begin
              if (m_ramp[i] + STP >= m_level[i]) begin
                m_ramp[i] = m_level[i];
                m_dir[i] = 1;
              end else m_ramp[i] += STP;
            end else begin
              if (m_ramp[i] <= STP) begin
                m_ramp[i] = 0;
                m_dir[i] = 0;
              end else m_ramp[i] -= STP;
            end
          end
        end
        if (m_was_pend) m_pend = 0;
      end
      if (cfg_valid && !m_was_pend) begin
        m_pend = 1;
        m_pch = int'(cfg_ch);
        m_pmode = int'(cfg_mode);
        m_plevel = int'(cfg_level);
      end
      exp_ready = !m_pend;
    end
  end

  bit chk_on = 0;
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      check("pwm_out", int'(pwm_out), int'(exp_pwm));
      check("period_end", int'(period_end), int'(exp_pe));
      check("cfg_ready", int'(cfg_ready), int'(exp_ready));
    end
  end

  // Driver phase is 3 time units after a rising edge
  task automatic send(input int ch, input int mode, input int level,
                      output int stall, output bit saw_pe);
    bit acc;
    acc = 0;
    stall = 0;
    saw_pe = 0;
    cfg_ch = 3'(ch);
    cfg_mode = 2'(mode);
    cfg_level = 4'(level);
    cfg_valid = 1'b1;
    while (!acc && stall < 100) begin
      acc = cfg_ready;
      saw_pe = period_end;
      @(posedge clk);
      #3;
      if (!acc) stall++;
    end
    cfg_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  int cnt [8][NCH];

  // Sync to the next period_end, then count high cycles for nper whole periods
  task automatic measure(input int nper);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!period_end && k < 40);
    if (!period_end) check("measure_sync", 0, 1);
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < NCH; c++) cnt[p][c] = 0;
    for (int p = 0; p < nper; p++) begin
      repeat (PERIOD) begin
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) cnt[p][c] += int'(pwm_out[c]);
      end
    end
    #2;
  endtask

  task automatic count_window(input int ncyc, output int npe, output int nhigh);
    npe = 0;
    nhigh = 0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      npe += int'(period_end);
      for (int c = 0; c < NCH; c++) nhigh += int'(pwm_out[c]);
    end
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

  int st, npe, nhigh, k;
  bit sp;
  int breathe_exp [8];

  initial begin
    breathe_exp = '{0, 4, 8, 10, 6, 2, 0, 4};
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1;
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_pe", int'(period_end), 0);
    check("reset_ready", int'(cfg_ready), 1);
    #2;
    rst_n = 1'b1;
    en = 1'b1;

    // Idle: no config, period_end every 16 clocks, outputs low
    count_window(48, npe, nhigh);
    check("idle_pe_count", npe, 3);
    check("idle_pwm_high", nhigh, 0);

    send(0, 1, 5, st, sp);
    measure(2);
    check("static5_p0", cnt[0][0], 5);
    check("static5_p1", cnt[1][0], 5);
    check("static5_ch1", cnt[0][1], 0);
    send(0, 1, 15, st, sp);
    measure(1);
    check("static15", cnt[0][0], 16);
    send(0, 1, 0, st, sp);
    measure(1);
    check("static0", cnt[0][0], 0);

    // Back-to-back words: second waits for the first commit
    send(0, 1, 5, st, sp);
    check("ready_low_pending", int'(cfg_ready), 0);
    send(1, 1, 3, st, sp);
    check("b2b_stalled", int'(st > 0), 1);
    check("b2b_accept_after_pe", int'(sp), 1);
    measure(1);
    check("b2b_ch0", cnt[0][0], 5);
    check("b2b_ch1", cnt[0][1], 3);

    send(5, 1, 15, st, sp);
    check("badch_no_stall", st, 0);
    measure(1);
    check("badch_ch0", cnt[0][0], 5);
    check("badch_ch1", cnt[0][1], 3);
    check("badch_ch2", cnt[0][2], 0);

    send(1, 2, 8, st, sp);
    measure(4);
    check("blink_sum", cnt[0][1] + cnt[1][1] + cnt[2][1] + cnt[3][1], 16);
    check("blink_alt02", cnt[0][1] + cnt[2][1], 8);
    check("blink_alt13", cnt[1][1] + cnt[3][1], 8);
    check("blink_ch0_static", cnt[2][0], 5);

    send(2, 3, 10, st, sp);
    measure(8);
    for (int p = 0; p < 8; p++) check($sformatf("breathe_p%0d", p), cnt[p][2], breathe_exp[p]);
    send(2, 1, 7, st, sp);
    measure(1);
    check("breathe_to_static", cnt[0][2], 7);
    send(2, 3, 10, st, sp);
    measure(2);
    check("rebreathe_p0", cnt[0][2], 0);
    check("rebreathe_p1", cnt[1][2], 4);

    // Enable dropped mid-period
    send(0, 1, 15, st, sp);
    measure(1);
    check("en_pre_ch0", cnt[0][0], 16);
    repeat (5) @(posedge clk);
    #3;
    en = 1'b0;
    @(posedge clk);
    #1;
    check("en_low_ch0", int'(pwm_out[0]), 0);
    #2;
    count_window(40, npe, nhigh);
    check("en_low_pe", npe, 0);
    check("en_low_high", nhigh, 0);
    en = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!period_end && k < 40);
    check("en_restart_pe_delay", k, 16);
    #2;

    // Reset while a word is pending
    send(0, 1, 9, st, sp);
    check("rst_pend_ready", int'(cfg_ready), 0);
    rst_n = 1'b0;
    #1;
    check("rst_async_pwm", int'(pwm_out), 0);
    check("rst_async_ready", int'(cfg_ready), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    measure(2);
    check("rst_drop_ch0", cnt[0][0] + cnt[1][0], 0);
    check("rst_drop_ch1", cnt[0][1] + cnt[1][1], 0);
    check("rst_drop_ch2", cnt[0][2] + cnt[1][2], 0);

    repeat (2) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
